// File: rtl/some_param_fifo_pkg.sv
// Shared widths, defaults and the class-side reflection target for the
// parameterised FIFO fixture.
package some_param_package;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Pointer width; a single-entry store still needs one address bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: must hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    class some_param_class #(
        parameter int WIDTH = DEFAULT_WIDTH,
        parameter int DEPTH = DEFAULT_DEPTH
    );
        function int get_width();
            return WIDTH;
        endfunction

        function int get_depth();
            return DEPTH;
        endfunction

        function int get_ptr_w();
            return ptr_w(DEPTH);
        endfunction

        function int get_cnt_w();
            return cnt_w(DEPTH);
        endfunction
    endclass

endpackage

// File: rtl/some_param_fifo_if.sv
// Ready/valid bundle for the FIFO: producer side, consumer side and status.
interface some_param_fifo_if
    import some_param_package::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    // Environment side: drives producer data and consumer acceptance.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, overflow, underflow
    );

endinterface

// File: rtl/some_param_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module some_param_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/some_param_fifo.sv
// Synchronous first-word-fall-through FIFO: pointer/count/flag control around
// an unreset storage array.
module some_param_fifo
    import some_param_package::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    some_param_fifo_if.slave    bus
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    cnt_t             count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full, empty, push, pop, mem_we;
    logic [WIDTH-1:0] rdata;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign push   = bus.in_valid & ~full;
    assign pop    = bus.out_ready & ~empty;
    // A flushed push must not land in storage either.
    assign mem_we = push & ~flush;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (bus.in_valid & full);
        underflow_d = underflow_q | (bus.out_ready & empty);
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    some_param_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (bus.in_data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : rdata;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // Equal pointers mean either empty or full; count disambiguates.
    ptr_t ptr_diff;
    assign ptr_diff = wr_ptr_q - rd_ptr_q;

    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        (count_q == CNT_W'(ptr_diff)) || ((ptr_diff == '0) && (count_q == FULL_CNT)));

    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);

endmodule

// File: tb/tb_some_param_fifo.sv
// Directed vector bench for some_param_fifo at WIDTH=8, DEPTH=4.
module tb_some_param_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    some_param_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

    some_param_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic [2:0] cnt;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad = 0;

    function automatic vec_t mk(logic iv, logic [7:0] d, logic ordy, logic fl,
                                logic [2:0] cnt, logic ir, logic ov, logic [7:0] od,
                                logic ovf, logic unf);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.cnt = cnt; v.ir = ir; v.ov = ov; v.od = od; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] cnt, input logic ir,
                             input logic ov, input logic [7:0] od, input logic ovf,
                             input logic unf);
        check({tag, ".count"},     32'(bus.count),     32'(cnt));
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        check({tag, ".out_data"},  32'(bus.out_data),  32'(od));
        check({tag, ".overflow"},  32'(bus.overflow),  32'(ovf));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(unf));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Push 0x11..0x33 with consumer stalled.
        vecs.push_back(mk(1, 8'h11, 0, 0, 3'd1, 1, 1, 8'h11, 0, 0));
        vecs.push_back(mk(1, 8'h22, 0, 0, 3'd2, 1, 1, 8'h11, 0, 0));
        vecs.push_back(mk(1, 8'h33, 0, 0, 3'd3, 1, 1, 8'h11, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 3'd0, 1, 0, 8'h00, 0, 0));
        // Fill, overflow attempt with 0xFF, drain.
        vecs.push_back(mk(1, 8'hA0, 0, 0, 3'd1, 1, 1, 8'hA0, 0, 0));
        vecs.push_back(mk(1, 8'hA1, 0, 0, 3'd2, 1, 1, 8'hA0, 0, 0));
        vecs.push_back(mk(1, 8'hA2, 0, 0, 3'd3, 1, 1, 8'hA0, 0, 0));
        vecs.push_back(mk(1, 8'hA3, 0, 0, 3'd4, 0, 1, 8'hA0, 0, 0));
        vecs.push_back(mk(1, 8'hFF, 0, 0, 3'd4, 0, 1, 8'hA0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd3, 1, 1, 8'hA1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd2, 1, 1, 8'hA2, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd1, 1, 1, 8'hA3, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd0, 1, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 3'd0, 1, 0, 8'h00, 0, 0));
        // Full with simultaneous push attempt and pop.
        vecs.push_back(mk(1, 8'hB0, 0, 0, 3'd1, 1, 1, 8'hB0, 0, 0));
        vecs.push_back(mk(1, 8'hB1, 0, 0, 3'd2, 1, 1, 8'hB0, 0, 0));
        vecs.push_back(mk(1, 8'hB2, 0, 0, 3'd3, 1, 1, 8'hB0, 0, 0));
        vecs.push_back(mk(1, 8'hB3, 0, 0, 3'd4, 0, 1, 8'hB0, 0, 0));
        vecs.push_back(mk(1, 8'h55, 1, 0, 3'd3, 1, 1, 8'hB1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd2, 1, 1, 8'hB2, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd1, 1, 1, 8'hB3, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd0, 1, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 3'd0, 1, 0, 8'h00, 0, 0));
        // Half full, six simultaneous push/pop cycles wrap both pointers.
        vecs.push_back(mk(1, 8'hC0, 0, 0, 3'd1, 1, 1, 8'hC0, 0, 0));
        vecs.push_back(mk(1, 8'hC1, 0, 0, 3'd2, 1, 1, 8'hC0, 0, 0));
        vecs.push_back(mk(1, 8'h70, 1, 0, 3'd2, 1, 1, 8'hC1, 0, 0));
        vecs.push_back(mk(1, 8'h71, 1, 0, 3'd2, 1, 1, 8'h70, 0, 0));
        vecs.push_back(mk(1, 8'h72, 1, 0, 3'd2, 1, 1, 8'h71, 0, 0));
        vecs.push_back(mk(1, 8'h73, 1, 0, 3'd2, 1, 1, 8'h72, 0, 0));
        vecs.push_back(mk(1, 8'h74, 1, 0, 3'd2, 1, 1, 8'h73, 0, 0));
        vecs.push_back(mk(1, 8'h75, 1, 0, 3'd2, 1, 1, 8'h74, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd1, 1, 1, 8'h75, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd0, 1, 0, 8'h00, 0, 0));
        // Overflow set at count=3, then flush with a concurrent push.
        vecs.push_back(mk(1, 8'hD0, 0, 0, 3'd1, 1, 1, 8'hD0, 0, 0));
        vecs.push_back(mk(1, 8'hD1, 0, 0, 3'd2, 1, 1, 8'hD0, 0, 0));
        vecs.push_back(mk(1, 8'hD2, 0, 0, 3'd3, 1, 1, 8'hD0, 0, 0));
        vecs.push_back(mk(1, 8'hD3, 0, 0, 3'd4, 0, 1, 8'hD0, 0, 0));
        vecs.push_back(mk(1, 8'hEE, 0, 0, 3'd4, 0, 1, 8'hD0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd3, 1, 1, 8'hD1, 1, 0));
        vecs.push_back(mk(1, 8'h99, 0, 1, 3'd0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 3'd0, 1, 0, 8'h00, 0, 0));
        // Underflow on empty, then a push keeps the sticky flag.
        vecs.push_back(mk(0, 8'h00, 1, 0, 3'd0, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 8'h5A, 0, 0, 3'd1, 1, 1, 8'h5A, 0, 1));

        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_all("reset", 3'd0, 1, 0, 8'h00, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.in_valid  = vecs[i].iv;
            bus.in_data   = vecs[i].d;
            bus.out_ready = vecs[i].ordy;
            flush         = vecs[i].fl;
            @(posedge clk);
            #1;
            $display("vec %0d: iv=%0d d=%02h ordy=%0d fl=%0d -> count=%0d out_valid=%0d out_data=%02h ovf=%0d unf=%0d",
                     i, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl,
                     bus.count, bus.out_valid, bus.out_data, bus.overflow, bus.underflow);
            check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ir, vecs[i].ov,
                      vecs[i].od, vecs[i].ovf, vecs[i].unf);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;

        // Mid-cycle reset drop: state must clear before the next edge.
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-cycle: count=%0d underflow=%0d", bus.count, bus.underflow);
        check_all("midreset", 3'd0, 1, 0, 8'h00, 0, 0);

        // Release away from an edge; first push lands on the first edge, no bypass.
        @(negedge clk);
        rst_n         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h61;
        #1;
        check("nobypass.out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        $display("first push after reset: count=%0d out_data=%02h", bus.count, bus.out_data);
        check_all("postreset", 3'd1, 1, 1, 8'h61, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/some_param_fifo.md
Name: some_param_fifo

Overview:
- Parametrised synchronous FIFO; the next-generation unit-test target for the reflection library.
- It replaces the fixed, class-only fixture with a parameterised hardware fixture that has real state: storage, pointers, counters and flags.
- Reflection unit tests elaborate it at several WIDTH/DEPTH values to exercise parameter and hierarchy introspection.
- Simulation benches also use it as a known-good ready/valid buffer.

Parameters:
- WIDTH, 8, data bits per entry (>=1).
- DEPTH, 4, number of entries (>=2, power of two).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- flush  input  1  synchronous clear of contents.
- in_valid  input  1  producer has data.
- in_ready  output  1  FIFO can accept (= !full).
- in_data  input  WIDTH  write data.
- out_valid  output  1  FIFO has data (= !empty).
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  head entry, first-word-fall-through.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: in_valid seen while full.
- underflow  output  1  sticky: out_ready seen while empty.

Behaviour:
- Reset (rst_n=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, in_ready=1, out_valid=0, overflow=0, underflow=0.
  - out_data is don't-care but must drive 0 while empty.
  - Storage array is not reset.
- Push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the same edge.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 by natural overflow. count is held separately.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. Write to wr_ptr and read from rd_ptr both occur, and both pointers advance.
- Full (count==DEPTH):
  - in_ready=0, so no push occurs.
  - A simultaneous pop is still permitted; in_ready stays combinationally 0 that cycle (no bypass from out_ready to in_ready).
- Empty (count==0):
  - out_valid=0, so no pop occurs.
  - A write is visible on out_data/out_valid one cycle after the push edge. There is no same-cycle bypass. Latency in->out is 1 cycle.
- out_data = mem[rd_ptr], combinational from registered pointer and storage.
- flush=1 at an edge: pointers and count go to 0.
  - Any push or pop in the same cycle is discarded.
  - overflow/underflow are also cleared.
  - flush has priority over all other updates.
- overflow sets on any edge with in_valid=1 and count==DEPTH. underflow sets on any edge with out_ready=1 and count==0. Both stay set until flush or reset.
- rst_n asserted mid-transfer: all state is cleared immediately. The first push after rst_n deassertion is taken on the first edge with rst_n=1.
- Output relations:
  - in_ready and out_valid are pure functions of count; no other logic feeds them.
  - count never exceeds DEPTH.
- Assertion (simulation only): count==(wr_ptr-rd_ptr) mod DEPTH, or count==DEPTH when pointers are equal and nonzero occupancy.

Decomposition:
- Shared package some_param_package holds:
  - typedef helpers: ptr_t width function and cnt_t width function.
  - constants: DEFAULT_WIDTH=8, DEFAULT_DEPTH=4.
  - a reflection-target class some_param_class #(WIDTH, DEPTH) mirroring the parameters for class-side introspection tests.
- One sub-module: some_param_fifo_mem, DEPTH x WIDTH.
  - One write port: we, waddr, wdata.
  - One asynchronous read port: raddr -> rdata.
  - No reset.
- Control (pointers, count, flags) stays in some_param_fifo.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 with out_ready=0 -> count=3, out_data=0x11 from cycle after first push, in_ready=1.
- DEPTH=4: push 0xA0..0xA3, then hold in_valid with 0xFF for 1 cycle -> count=4, in_ready=0, overflow=1. Drain gives 0xA0,0xA1,0xA2,0xA3; 0xFF is never seen.
- Full FIFO, simultaneous in_valid=1 (0x55) and out_ready=1 -> pop of head only, count 4->3. Next cycle in_ready=1.
- Half-full (count=2), simultaneous push 0x77 and pop for 6 cycles -> count stays 2. Pointers wrap past DEPTH-1 with order preserved.
- count=3, overflow=1, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, overflow=0. Pushed word is discarded.
- Empty, out_ready=1 -> underflow=1, count stays 0. Push 0x5A, then drop rst_n asynchronously mid-cycle -> count=0 and underflow=0 before the next edge.
